// File: rtl/wrap_led_stepper_if.sv
// Control and LED bundle between the slow-tick consumer and its neighbours.
// The master drives controls and the tick level; the slave returns LED state and events.
interface wrap_led_stepper_if #(
    parameter int WIDTH = 16
) ();
    logic             tick_clk;
    logic             en;
    logic             dir;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_pat;
    logic [WIDTH-1:0] led;
    logic             step;
    logic             wrap;
    logic [7:0]       wrap_cnt;

    modport master (
        output tick_clk, en, dir, mode, load, load_pat,
        input  led, step, wrap, wrap_cnt
    );

    modport slave (
        input  tick_clk, en, dir, mode, load, load_pat,
        output led, step, wrap, wrap_cnt
    );
endinterface

// File: rtl/wrap_led_stepper.sv
// LED pattern stepper: synchronizes a slow tick level and advances the pattern
// on each rising edge, either rotating with wrap-around or bouncing between ends.
module wrap_led_stepper #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic               clk,
    input logic               rst,
    wrap_led_stepper_if.slave bus
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   tp_q, tp_d;
    logic                   bd_q, bd_d;
    logic [WIDTH-1:0]       led_q, led_d;
    logic                   step_q, step_d;
    logic                   wrap_q, wrap_d;
    logic [7:0]             cnt_q, cnt_d;

    logic             ts;
    logic             tick_edge;
    logic             fwd_drop;
    logic             back_drop;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;

    assign ts        = sync_q[SYNC_STAGES-1];
    assign tick_edge = ts & ~tp_q;
    assign shl       = {led_q[WIDTH-2:0], 1'b0};
    assign shr       = {1'b0, led_q[WIDTH-1:1]};
    // Bits lost by a forward (bd) shift and by the reversed shift.
    assign fwd_drop  = bd_q ? led_q[0] : led_q[WIDTH-1];
    assign back_drop = bd_q ? led_q[WIDTH-1] : led_q[0];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.tick_clk};
        tp_d   = ts;
        bd_d   = bus.mode ? bd_q : bus.dir;
        led_d  = led_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (bus.load) begin
            led_d = bus.load_pat;
        end else if (tick_edge && bus.en) begin
            step_d = 1'b1;
            if (!bus.mode) begin
                if (bus.dir) begin
                    led_d  = {led_q[0], led_q[WIDTH-1:1]};
                    wrap_d = led_q[0];
                end else begin
                    led_d  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    wrap_d = led_q[WIDTH-1];
                end
            end else if (!fwd_drop) begin
                led_d = bd_q ? shr : shl;
            end else begin
                wrap_d = 1'b1;
                bd_d   = ~bd_q;
                if (!back_drop) begin
                    led_d = bd_q ? shl : shr;
                end
            end
        end
        cnt_d = cnt_q + {7'd0, wrap_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            tp_q   <= 1'b0;
            bd_q   <= 1'b0;
            led_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            sync_q <= sync_d;
            tp_q   <= tp_d;
            bd_q   <= bd_d;
            led_q  <= led_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.step     = step_q;
    assign bus.wrap     = wrap_q;
    assign bus.wrap_cnt = cnt_q;
endmodule

// File: tb/tb_wrap_led_stepper.sv
// Directed bench for wrap_led_stepper: latency, rotate, bounce, controls,
// counter rollover and asynchronous reset.
module tb_wrap_led_stepper;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   sc;
    int   wc;

    wrap_led_stepper_if #(.WIDTH(16)) bus ();

    wrap_led_stepper #(
        .WIDTH(16),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count step/wrap pulses over n cycles, sampled 1 ns after each edge.
    task automatic count(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sc += int'(bus.step);
            wc += int'(bus.wrap);
        end
    endtask

    task automatic do_tick();
        sc = 0;
        wc = 0;
        bus.tick_clk = 1'b1;
        count(8);
        bus.tick_clk = 1'b0;
        count(4);
    endtask

    task automatic do_load(input logic [15:0] p);
        bus.load     = 1'b1;
        bus.load_pat = p;
        cyc(1);
        bus.load     = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_err        = 0;
        rst          = 1'b0;
        bus.tick_clk = 1'b0;
        bus.en       = 1'b1;
        bus.dir      = 1'b0;
        bus.mode     = 1'b0;
        bus.load     = 1'b0;
        bus.load_pat = '0;
        cyc(3);
        chk("rst_led", bus.led, 32'h0001);
        chk("rst_step", bus.step, 0);
        chk("rst_wrap", bus.wrap, 0);
        chk("rst_cnt", bus.wrap_cnt, 0);
        rst = 1'b1;
        cyc(2);

        // Latency: update lands two edges after the first sampling edge.
        bus.tick_clk = 1'b1;
        cyc(1);
        chk("lat_k", bus.led, 32'h0001);
        cyc(1);
        chk("lat_k1", bus.led, 32'h0001);
        chk("lat_k1_step", bus.step, 0);
        cyc(1);
        chk("lat_k2", bus.led, 32'h0002);
        chk("lat_step", bus.step, 1);
        chk("lat_wrap", bus.wrap, 0);
        cyc(1);
        chk("lat_step_off", bus.step, 0);
        bus.tick_clk = 1'b0;
        cyc(4);

        do_load(16'h8000);
        do_tick();
        chk("wl_led", bus.led, 32'h0001);
        chk("wl_steps", sc, 1);
        chk("wl_wraps", wc, 1);
        chk("wl_cnt", bus.wrap_cnt, 1);

        bus.dir = 1'b1;
        do_load(16'h0001);
        do_tick();
        chk("wr_led", bus.led, 32'h8000);
        chk("wr_wraps", wc, 1);
        chk("wr_cnt", bus.wrap_cnt, 2);

        // Bounce starting left.
        bus.dir = 1'b0;
        do_load(16'h4000);
        bus.mode = 1'b1;
        do_tick();
        chk("b1_led", bus.led, 32'h8000);
        chk("b1_wraps", wc, 0);
        do_tick();
        chk("b2_led", bus.led, 32'h4000);
        chk("b2_wraps", wc, 1);
        chk("b2_cnt", bus.wrap_cnt, 3);
        do_tick();
        chk("b3_led", bus.led, 32'h2000);
        chk("b3_wraps", wc, 0);

        do_load(16'h8001);
        do_tick();
        chk("bb1_led", bus.led, 32'h8001);
        chk("bb1_wraps", wc, 1);
        do_tick();
        chk("bb2_led", bus.led, 32'h8001);
        chk("bb2_wraps", wc, 1);
        chk("bb2_cnt", bus.wrap_cnt, 5);

        bus.mode = 1'b0;
        do_load(16'h0010);
        bus.en = 1'b0;
        do_tick();
        chk("en0_steps1", sc, 0);
        do_tick();
        chk("en0_steps2", sc, 0);
        chk("en0_led", bus.led, 32'h0010);

        // Enable while the tick is already high.
        sc = 0;
        bus.tick_clk = 1'b1;
        cyc(6);
        bus.en = 1'b1;
        count(6);
        bus.tick_clk = 1'b0;
        count(4);
        chk("en_hi_steps", sc, 0);
        chk("en_hi_led", bus.led, 32'h0010);
        do_tick();
        chk("en_next_steps", sc, 1);
        chk("en_next_led", bus.led, 32'h0020);

        // Load on the same edge the step would fire.
        bus.tick_clk = 1'b1;
        cyc(2);
        bus.load     = 1'b1;
        bus.load_pat = 16'h0F0F;
        cyc(1);
        bus.load     = 1'b0;
        chk("ld_led", bus.led, 32'h0F0F);
        chk("ld_step", bus.step, 0);
        sc = 0;
        count(5);
        bus.tick_clk = 1'b0;
        count(4);
        chk("ld_late_steps", sc, 0);
        chk("ld_cnt", bus.wrap_cnt, 5);

        do_load(16'h0000);
        do_tick();
        chk("z_steps", sc, 1);
        chk("z_wraps", wc, 0);
        chk("z_led", bus.led, 32'h0000);

        // 251 more wraps takes the counter from 5 through 255 to 0.
        do_load(16'hFFFF);
        begin
            int tw;
            tw = 0;
            for (int i = 0; i < 251; i++) begin
                do_tick();
                tw += wc;
            end
            chk("roll_wraps", tw, 251);
        end
        chk("roll_cnt", bus.wrap_cnt, 0);
        chk("roll_led", bus.led, 32'hFFFF);

        // Reset between the edge and the update.
        do_load(16'h0100);
        bus.tick_clk = 1'b1;
        cyc(2);
        rst = 1'b0;
        #1;
        chk("mrst_led", bus.led, 32'h0001);
        chk("mrst_step", bus.step, 0);
        chk("mrst_cnt", bus.wrap_cnt, 0);
        cyc(1);
        rst = 1'b1;
        sc = 0;
        count(6);
        bus.tick_clk = 1'b0;
        count(4);
        chk("mrst_steps", sc, 1);
        chk("mrst_after", bus.led, 32'h0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
